// File: rtl/pipe_mips_core.sv
// Five-stage pipelined MIPS subset core with internal instruction/data memories and register file.
// Operands are forwarded into EX, lw has a one-cycle use interlock, and beq/j redirect fetch from EX.

module pipe_mips_im #(
    parameter int IM_WORDS = 1024
) (
    input  logic [9:0]  addr,
    output logic [31:0] dout
);
    logic [31:0] IMem [IM_WORDS];

    assign dout = IMem[addr];
endmodule

module pipe_mips_pcunit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pcout
);
    // Fetch PC: a redirect beats a stall, otherwise step one word (wraps at 2^32)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          pcout <= RESET_PC;
        else if (redirect) pcout <= target;
        else if (stall)    pcout <= pcout;
        else               pcout <= pcout + 32'd4;
    end
endmodule

module pipe_mips_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [32];

    // Register write from WB; $0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end else begin
            regs[0] <= 32'd0;
        end
    end

    // A WB write in the same cycle is visible to the ID read
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : ((we && (wa == ra2)) ? wd : regs[ra2]);
endmodule

module pipe_mips_dm #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [31:0] DMem [DM_WORDS];

    // Word store on sw in MEM; reset clears the whole store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DM_WORDS; i++) DMem[i] <= 32'd0;
        end else if (we) begin
            DMem[addr] <= wd;
        end else begin
            DMem[addr] <= DMem[addr];
        end
    end

    assign rd = DMem[addr];
endmodule

module pipe_mips_core #(
    parameter int          IM_WORDS = 1024,
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
        ALU_SLT = 3'd4, ALU_SLL = 3'd5, ALU_PASSB = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    alusrc;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [25:0] jidx;
    } idex_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  dest;
    } exmem_t;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  dest;
        logic [31:0] val;
    } memwb_t;

    logic [31:0] pc_s, im_OpCode, target_s;
    logic        stall_s, redirect_s, load_use_s;
    logic [31:0] ifid_instr_r, ifid_pc4_r;
    logic [31:0] rs_val_s, rt_val_s, fwd_a_s, fwd_b_s, alu_b_s, alu_res_s, dm_rdata_s;
    ctrl_t       ctrl_s;
    idex_t       idex_s, idex_r;
    exmem_t      exmem_r;
    memwb_t      memwb_r;

    function automatic logic [31:0] fwd_sel(input logic [4:0] src, input logic [31:0] dflt,
                                            input exmem_t em, input memwb_t mw);
        if (em.regwrite && (em.dest != 5'd0) && (em.dest == src))      return em.alu;
        else if (mw.regwrite && (mw.dest != 5'd0) && (mw.dest == src)) return mw.val;
        else                                                           return dflt;
    endfunction

    pipe_mips_pcunit #(.RESET_PC(RESET_PC)) U_pipe_PcUnit (
        .clk(clk), .rst(rst), .stall(stall_s), .redirect(redirect_s), .target(target_s), .pcout(pc_s)
    );
    pipe_mips_im #(.IM_WORDS(IM_WORDS)) U_IM (.addr(pc_s[11:2]), .dout(im_OpCode));
    pipe_mips_rf U_RF (
        .clk(clk), .rst(rst), .ra1(ifid_instr_r[25:21]), .ra2(ifid_instr_r[20:16]),
        .rd1(rs_val_s), .rd2(rt_val_s), .we(memwb_r.regwrite), .wa(memwb_r.dest), .wd(memwb_r.val)
    );
    pipe_mips_dm #(.DM_WORDS(DM_WORDS)) U_DM (
        .clk(clk), .rst(rst), .addr(exmem_r.alu[11:2]), .we(exmem_r.memwrite),
        .wd(exmem_r.store), .rd(dm_rdata_s)
    );

    // IF/ID: flushed on redirect, held during the load-use interlock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_r <= 32'd0;
            ifid_pc4_r   <= 32'd0;
        end else if (redirect_s) begin
            ifid_instr_r <= 32'd0;
            ifid_pc4_r   <= 32'd0;
        end else if (stall_s) begin
            ifid_instr_r <= ifid_instr_r;
            ifid_pc4_r   <= ifid_pc4_r;
        end else begin
            ifid_instr_r <= im_OpCode;
            ifid_pc4_r   <= pc_s + 32'd4;
        end
    end

    // Decode: unknown opcodes/functs leave every control bit clear and so act as NOP
    always_comb begin
        ctrl_s = '0;
        idex_s = '0;
        idex_s.imm = {{16{ifid_instr_r[15]}}, ifid_instr_r[15:0]};
        idex_s.dest = 5'd0;
        case (ifid_instr_r[31:26])
            6'b000000: begin
                idex_s.dest     = ifid_instr_r[15:11];
                ctrl_s.regwrite = 1'b1;
                case (ifid_instr_r[5:0])
                    6'b100001: ctrl_s.alu_op = ALU_ADD;
                    6'b100011: ctrl_s.alu_op = ALU_SUB;
                    6'b100100: ctrl_s.alu_op = ALU_AND;
                    6'b100101: ctrl_s.alu_op = ALU_OR;
                    6'b101010: ctrl_s.alu_op = ALU_SLT;
                    6'b000000: ctrl_s.alu_op = ALU_SLL;
                    default:   ctrl_s.regwrite = 1'b0;
                endcase
            end
            6'b001001: begin
                ctrl_s.regwrite = 1'b1; ctrl_s.alusrc = 1'b1; idex_s.dest = ifid_instr_r[20:16];
            end
            6'b001101: begin
                ctrl_s.regwrite = 1'b1; ctrl_s.alusrc = 1'b1; ctrl_s.alu_op = ALU_OR;
                idex_s.dest = ifid_instr_r[20:16];
                idex_s.imm  = {16'd0, ifid_instr_r[15:0]};
            end
            6'b001111: begin
                ctrl_s.regwrite = 1'b1; ctrl_s.alusrc = 1'b1; ctrl_s.alu_op = ALU_PASSB;
                idex_s.dest = ifid_instr_r[20:16];
                idex_s.imm  = {ifid_instr_r[15:0], 16'd0};
            end
            6'b100011: begin
                ctrl_s.regwrite = 1'b1; ctrl_s.memread = 1'b1; ctrl_s.alusrc = 1'b1;
                idex_s.dest = ifid_instr_r[20:16];
            end
            6'b101011: begin
                ctrl_s.memwrite = 1'b1; ctrl_s.alusrc = 1'b1;
            end
            6'b000100: ctrl_s.branch = 1'b1;
            6'b000010: ctrl_s.jump = 1'b1;
            default:   ctrl_s = '0;
        endcase
        idex_s.ctrl   = ctrl_s;
        idex_s.pc4    = ifid_pc4_r;
        idex_s.rs_val = rs_val_s;
        idex_s.rt_val = rt_val_s;
        idex_s.rs     = ifid_instr_r[25:21];
        idex_s.rt     = ifid_instr_r[20:16];
        idex_s.shamt  = ifid_instr_r[10:6];
        idex_s.jidx   = ifid_instr_r[25:0];
    end

    assign load_use_s = idex_r.ctrl.memread && (idex_r.dest != 5'd0) &&
                        ((idex_r.dest == ifid_instr_r[25:21]) || (idex_r.dest == ifid_instr_r[20:16]));
    assign stall_s    = load_use_s && !redirect_s;

    // ID/EX: bubble when the instruction in ID is squashed or must wait for a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         idex_r <= '0;
        else if (redirect_s || stall_s)   idex_r <= '0;
        else                              idex_r <= idex_s;
    end

    // EX: forwarded operands, ALU, and branch/jump resolution
    always_comb begin
        fwd_a_s = fwd_sel(idex_r.rs, idex_r.rs_val, exmem_r, memwb_r);
        fwd_b_s = fwd_sel(idex_r.rt, idex_r.rt_val, exmem_r, memwb_r);
        alu_b_s = idex_r.ctrl.alusrc ? idex_r.imm : fwd_b_s;
        case (idex_r.ctrl.alu_op)
            ALU_ADD:   alu_res_s = fwd_a_s + alu_b_s;
            ALU_SUB:   alu_res_s = fwd_a_s - alu_b_s;
            ALU_AND:   alu_res_s = fwd_a_s & alu_b_s;
            ALU_OR:    alu_res_s = fwd_a_s | alu_b_s;
            ALU_SLT:   alu_res_s = ($signed(fwd_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            ALU_SLL:   alu_res_s = fwd_b_s << idex_r.shamt;
            ALU_PASSB: alu_res_s = alu_b_s;
            default:   alu_res_s = 32'd0;
        endcase
        if (idex_r.ctrl.jump) begin
            target_s = {idex_r.pc4[31:28], idex_r.jidx, 2'b00};
        end else begin
            target_s = idex_r.pc4 + {idex_r.imm[29:0], 2'b00};
        end
        redirect_s = idex_r.ctrl.jump || (idex_r.ctrl.branch && (fwd_a_s == fwd_b_s));
    end

    // EX/MEM and MEM/WB pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_r <= '0;
            memwb_r <= '0;
        end else begin
            exmem_r.regwrite <= idex_r.ctrl.regwrite;
            exmem_r.memread  <= idex_r.ctrl.memread;
            exmem_r.memwrite <= idex_r.ctrl.memwrite;
            exmem_r.alu      <= alu_res_s;
            exmem_r.store    <= fwd_b_s;
            exmem_r.dest     <= idex_r.dest;
            memwb_r.regwrite <= exmem_r.regwrite;
            memwb_r.dest     <= exmem_r.dest;
            memwb_r.val      <= exmem_r.memread ? dm_rdata_s : exmem_r.alu;
        end
    end
endmodule

// File: tb/tb_pipe_mips_core.sv
// Directed-program bench for pipe_mips_core: loads small programs into instruction memory
// and checks PC, register file and data memory contents against hand-computed values.

module tb_pipe_mips_core;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] prog [128];

    pipe_mips_core dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'd0;
    endtask

    // Hold reset while loading the program, then release on a falling edge
    task automatic start_prog();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) dut.U_IM.IMem[i] = 32'd0;
        for (int i = 0; i < 128; i++) dut.U_IM.IMem[i] = prog[i];
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_holds(input int n, output int holds);
        logic [31:0] prev;
        holds = 0;
        prev  = dut.U_pipe_PcUnit.pcout;
        repeat (n) begin
            @(negedge clk);
            if (dut.U_pipe_PcUnit.pcout == prev) holds++;
            prev = dut.U_pipe_PcUnit.pcout;
        end
    endtask

    initial begin
        int          holds;
        logic [31:0] orr;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        #3 rst  = 1'b0;

        // Reset state and sequential fetch
        clear_prog();
        for (int i = 0; i < 1024; i++) dut.U_IM.IMem[i] = 32'd0;
        repeat (2) @(negedge clk);
        orr = 32'd0;
        for (int i = 0; i < 32; i++) orr = orr | dut.U_RF.regs[i];
        check_val("reset_pc", dut.U_pipe_PcUnit.pcout, 32'h0);
        check_val("reset_regs", orr, 32'h0);
        rst = 1'b1;
        check_val("pc_release", dut.U_pipe_PcUnit.pcout, 32'h0);
        @(negedge clk);
        check_val("pc_edge1", dut.U_pipe_PcUnit.pcout, 32'h4);
        @(negedge clk);
        check_val("pc_edge2", dut.U_pipe_PcUnit.pcout, 32'h8);

        // ALU chain with forwarding, no stalls
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h0D, 5'd0, 5'd2, 16'd7);
        prog[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        prog[3] = enc_r(5'd3, 5'd1, 5'd4, 5'd0, 6'h23);
        start_prog();
        run_holds(12, holds);
        check_val("chain_r3", dut.U_RF.regs[3], 32'd12);
        check_val("chain_r4", dut.U_RF.regs[4], 32'd7);
        check_val("chain_holds", holds, 32'd0);

        // Load-use: one interlock cycle, store data forwarded
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0010);
        prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0000);
        prog[2] = enc_i(6'h23, 5'd0, 5'd2, 16'h0000);
        prog[3] = enc_r(5'd2, 5'd2, 5'd3, 5'd0, 6'h21);
        start_prog();
        run_holds(12, holds);
        check_val("lu_dmem0", dut.U_DM.DMem[0], 32'h10);
        check_val("lu_r3", dut.U_RF.regs[3], 32'h20);
        check_val("lu_holds", holds, 32'd1);

        // Asynchronous reset mid-run discards state immediately
        #2 rst = 1'b0;
        #1;
        check_val("midrst_pc", dut.U_pipe_PcUnit.pcout, 32'h0);
        check_val("midrst_dmem0", dut.U_DM.DMem[0], 32'h0);
        check_val("midrst_r3", dut.U_RF.regs[3], 32'h0);

        // Taken beq skips one instruction
        clear_prog();
        prog[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        prog[1] = enc_i(6'h0D, 5'd0, 5'd5, 16'd1);
        prog[2] = enc_i(6'h0D, 5'd0, 5'd6, 16'd2);
        start_prog();
        repeat (12) @(negedge clk);
        check_val("beq_r5", dut.U_RF.regs[5], 32'd0);
        check_val("beq_r6", dut.U_RF.regs[6], 32'd2);

        // Untaken beq falls through
        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_i(6'h0D, 5'd0, 5'd2, 16'd2);
        prog[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
        prog[3] = enc_i(6'h0D, 5'd0, 5'd5, 16'd3);
        prog[4] = enc_i(6'h0D, 5'd0, 5'd6, 16'd4);
        start_prog();
        repeat (14) @(negedge clk);
        check_val("bne_r5", dut.U_RF.regs[5], 32'd3);
        check_val("bne_r6", dut.U_RF.regs[6], 32'd4);

        // Jump to word 0x40; the two fetched-behind instructions must not execute
        clear_prog();
        prog[0]  = {6'h02, 26'h40};
        prog[1]  = enc_i(6'h0D, 5'd0, 5'd9, 16'd1);
        prog[2]  = enc_i(6'h0D, 5'd0, 5'd9, 16'd1);
        prog[64] = enc_i(6'h0D, 5'd0, 5'd10, 16'h0055);
        start_prog();
        repeat (3) @(negedge clk);
        check_val("j_pc", dut.U_pipe_PcUnit.pcout, 32'h100);
        repeat (8) @(negedge clk);
        check_val("j_r9", dut.U_RF.regs[9], 32'd0);
        check_val("j_r10", dut.U_RF.regs[10], 32'h55);

        // lui / slt / sll / ori / addiu / and / wraparound arithmetic
        clear_prog();
        prog[0] = enc_i(6'h0F, 5'd0, 5'd7, 16'h8000);
        prog[1] = enc_r(5'd7, 5'd0, 5'd8, 5'd0, 6'h2A);
        prog[2] = enc_r(5'd0, 5'd7, 5'd11, 5'd0, 6'h2A);
        prog[3] = enc_i(6'h0D, 5'd0, 5'd1, 16'd3);
        prog[4] = enc_r(5'd0, 5'd1, 5'd12, 5'd4, 6'h00);
        prog[5] = enc_i(6'h0D, 5'd0, 5'd13, 16'h8000);
        prog[6] = enc_i(6'h09, 5'd0, 5'd14, 16'hFFFF);
        prog[7] = enc_r(5'd13, 5'd14, 5'd15, 5'd0, 6'h24);
        prog[8] = enc_r(5'd14, 5'd1, 5'd16, 5'd0, 6'h21);
        prog[9] = enc_r(5'd0, 5'd1, 5'd21, 5'd0, 6'h23);
        start_prog();
        repeat (18) @(negedge clk);
        check_val("lui_r7", dut.U_RF.regs[7], 32'h8000_0000);
        check_val("slt_neg", dut.U_RF.regs[8], 32'd1);
        check_val("slt_pos", dut.U_RF.regs[11], 32'd0);
        check_val("sll_r12", dut.U_RF.regs[12], 32'h30);
        check_val("ori_zext", dut.U_RF.regs[13], 32'h0000_8000);
        check_val("addiu_sext", dut.U_RF.regs[14], 32'hFFFF_FFFF);
        check_val("and_r15", dut.U_RF.regs[15], 32'h0000_8000);
        check_val("addu_wrap", dut.U_RF.regs[16], 32'd2);
        check_val("subu_wrap", dut.U_RF.regs[21], 32'hFFFF_FFFD);

        // $0 stays zero and is not forwarded; undefined encodings change nothing
        clear_prog();
        prog[0] = enc_i(6'h09, 5'd0, 5'd0, 16'd9);
        prog[1] = enc_i(6'h09, 5'd0, 5'd17, 16'd1);
        prog[2] = enc_i(6'h3F, 5'd0, 5'd18, 16'h1234);
        prog[3] = enc_r(5'd0, 5'd0, 5'd19, 5'd0, 6'h3F);
        prog[4] = enc_i(6'h0D, 5'd0, 5'd20, 16'h0077);
        start_prog();
        run_holds(12, holds);
        check_val("r0_zero", dut.U_RF.regs[0], 32'd0);
        check_val("r0_nofwd", dut.U_RF.regs[17], 32'd1);
        check_val("undef_op", dut.U_RF.regs[18], 32'd0);
        check_val("undef_fn", dut.U_RF.regs[19], 32'd0);
        check_val("after_undef", dut.U_RF.regs[20], 32'h77);
        check_val("undef_pc", dut.U_pipe_PcUnit.pcout, 32'd48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
